// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: opcode map shared by the ROM image, fetch unit and control unit,
// plus the fetch FSM encoding and opcode classification helpers.
package instr_fetch_unit_pkg;

    localparam int OP_W = 8;

    typedef enum logic [OP_W-1:0] {
        BRA       = 8'h20,
        BMI       = 8'h21,
        BPL       = 8'h22,
        BEQ       = 8'h23,
        BNE       = 8'h24,
        BVS       = 8'h25,
        BVC       = 8'h26,
        BCS       = 8'h27,
        BCC       = 8'h28,
        ADD_AB    = 8'h42,
        SUB_AB    = 8'h43,
        AND_AB    = 8'h44,
        OR_AB     = 8'h45,
        INCA      = 8'h46,
        INCB      = 8'h47,
        DECA      = 8'h48,
        DECB      = 8'h49,
        XOR_AB    = 8'h4A,
        NOTA      = 8'h4B,
        NOTB      = 8'h4C,
        ADDAB_LDB = 8'h4D,
        LDA_IMM   = 8'h86,
        LDA_DIR   = 8'h87,
        LDB_IMM   = 8'h88,
        LDB_DIR   = 8'h89,
        STA_DIR   = 8'h96,
        STB_DIR   = 8'h97
    } opcode_e;

    typedef enum logic [2:0] {
        S_ADDR_OP,
        S_LAT_OP,
        S_ADDR_OPR,
        S_LAT_OPR,
        S_PRESENT
    } ifu_state_t;

    // Loads, stores and branches carry an operand byte.
    function automatic logic is_two_byte(input logic [OP_W-1:0] op);
        return op inside {[BRA:BCC], [LDA_IMM:LDB_DIR], STA_DIR, STB_DIR};
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return is_two_byte(op) || (op inside {[ADD_AB:ADDAB_LDB]});
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: ROM read port, instruction valid/ready handshake and branch redirect
// of the fetch unit; master is the fetch unit, slave is the ROM/execute side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_opcode;
    logic [DATA_W-1:0] instr_operand;
    logic              instr_two_byte;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              trap;

    modport master (
        output rom_address, instr_valid, instr_opcode, instr_operand, instr_two_byte, instr_pc, trap,
        input  rom_data, instr_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  rom_address, instr_valid, instr_opcode, instr_operand, instr_two_byte, instr_pc, trap,
        output rom_data, instr_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/instr_fetch_unit_opcode_decode.sv
// ifu_opcode_decode: combinational opcode classification into {two_byte, legal}.
module ifu_opcode_decode
    import instr_fetch_unit_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] opcode,
    output logic              two_byte,
    output logic              legal
);
    assign two_byte = is_two_byte(OP_W'(opcode));
    assign legal    = is_legal(OP_W'(opcode));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads the 128x8 synchronous ROM and hands out 1/2-byte instructions.
// Define IFU_ILLEGAL_TRAP_EN to divert illegal opcodes to TRAP_VECTOR with a one-cycle trap pulse.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 8,
    parameter int                ROM_DEPTH    = 128,
`ifdef IFU_ILLEGAL_TRAP_EN
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 8'h7E,
`endif
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    ifu_state_t        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_inc, redirect_pc;
    logic [ADDR_W-1:0] instr_pc, instr_pc_n;
    logic [DATA_W-1:0] opcode, opcode_n, operand, operand_n;
    logic              two_byte, two_byte_n;
    logic              dec_two_byte, dec_legal;

    ifu_opcode_decode #(.DATA_W(DATA_W)) u_dec (
        .opcode   (bus.rom_data),
        .two_byte (dec_two_byte),
        .legal    (dec_legal)
    );

    assign pc_inc      = (32'(pc) == ROM_DEPTH - 1) ? '0 : pc + 1'b1;
    assign redirect_pc = ADDR_W'(32'(bus.redirect_addr) % ROM_DEPTH);

`ifdef IFU_ILLEGAL_TRAP_EN
    logic trap_q, trap_n;
    assign bus.trap = trap_q;
`else
    assign bus.trap = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        opcode_n   = opcode;
        operand_n  = operand;
        two_byte_n = two_byte;
        instr_pc_n = instr_pc;
`ifdef IFU_ILLEGAL_TRAP_EN
        trap_n     = 1'b0;
`endif
        case (state)
            S_ADDR_OP:  state_n = S_LAT_OP;
            S_LAT_OP: begin
                opcode_n   = bus.rom_data;
                operand_n  = '0;
                instr_pc_n = pc;
                pc_n       = pc_inc;
                two_byte_n = dec_two_byte && dec_legal;
                state_n    = two_byte_n ? S_ADDR_OPR : S_PRESENT;
`ifdef IFU_ILLEGAL_TRAP_EN
                if (!dec_legal) begin
                    pc_n    = TRAP_VECTOR;
                    state_n = S_ADDR_OP;
                    trap_n  = 1'b1;
                end
`endif
            end
            S_ADDR_OPR: state_n = S_LAT_OPR;
            S_LAT_OPR: begin
                operand_n = bus.rom_data;
                pc_n      = pc_inc;
                state_n   = S_PRESENT;
            end
            S_PRESENT:  state_n = bus.instr_ready ? S_ADDR_OP : S_PRESENT;
            default:    state_n = S_ADDR_OP;
        endcase
        // A taken branch overrides everything, including an accepted transfer or a trap.
        if (bus.redirect_valid) begin
            pc_n    = redirect_pc;
            state_n = S_ADDR_OP;
`ifdef IFU_ILLEGAL_TRAP_EN
            trap_n  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_ADDR_OP;
            pc       <= RESET_VECTOR;
            opcode   <= '0;
            operand  <= '0;
            two_byte <= 1'b0;
            instr_pc <= '0;
`ifdef IFU_ILLEGAL_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            opcode   <= opcode_n;
            operand  <= operand_n;
            two_byte <= two_byte_n;
            instr_pc <= instr_pc_n;
`ifdef IFU_ILLEGAL_TRAP_EN
            trap_q   <= trap_n;
`endif
        end
    end

    assign bus.rom_address    = pc;
    assign bus.instr_valid    = (state == S_PRESENT);
    assign bus.instr_opcode   = opcode;
    assign bus.instr_operand  = operand;
    assign bus.instr_two_byte = two_byte;
    assign bus.instr_pc       = instr_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table vectors, directed corner sequences and a randomized run
// against an instruction-level ROM-walk model of the fetch unit.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();
    instr_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] rom [128];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_address[6:0]];

    int n_chk = 0;
    int n_fail = 0;
    int lat, traps;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] opr;
        logic       tb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] opr, input logic tb, input logic [7:0] pc);
        return {op, opr, 7'b0, tb, pc};
    endfunction

    function automatic logic [31:0] dut_instr();
        return mk(bus.instr_opcode, bus.instr_operand, bus.instr_two_byte, bus.instr_pc);
    endfunction

    function automatic logic two_byte_op(input logic [7:0] op);
        return (op >= 8'h20 && op <= 8'h28) || (op >= 8'h86 && op <= 8'h89) || op == 8'h96 || op == 8'h97;
    endfunction

    function automatic logic legal_op(input logic [7:0] op);
        return two_byte_op(op) || (op >= 8'h42 && op <= 8'h4D);
    endfunction

    // Next instruction the unit should hand out when fetching from pc, and the pc after it.
    function automatic logic [31:0] model_instr(input int pc, output int nxt);
        logic [7:0] op, opr;
        logic       tb;
`ifdef IFU_ILLEGAL_TRAP_EN
        for (int k = 0; k < 4 && !legal_op(rom[pc]); k++) pc = 'h7E;
`else
        tb = legal_op(rom[pc]);
`endif
        op  = rom[pc];
        tb  = two_byte_op(op);
        opr = tb ? rom[(pc + 1) % 128] : 8'h00;
        nxt = (pc + (tb ? 2 : 1)) % 128;
        return mk(op, opr, tb, 8'(pc));
    endfunction

    task automatic redirect(input logic [7:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic get_instr(input string name);
        lat   = 0;
        traps = 0;
        do begin
            @(negedge clk);
            lat++;
            traps += int'(bus.trap);
        end while (!bus.instr_valid && lat < 20);
        if (!bus.instr_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no instr_valid within 20 cycles", name);
        end
    endtask

    task automatic pulse_ready();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        check("ready_drop_valid", bus.instr_valid, 0);
    endtask

    initial begin
        logic [31:0] t1 [5];
        vec_t        vecs [12];
        logic [31:0] e_ins;
        int          mpc, nxt, gap, transfers;

        t1[0] = mk(8'h86, 8'h00, 1'b1, 8'h00);
        t1[1] = mk(8'h88, 8'h01, 1'b1, 8'h02);
        t1[2] = mk(8'h42, 8'h00, 1'b0, 8'h04);
        t1[3] = mk(8'h4D, 8'h00, 1'b0, 8'h05);
        t1[4] = mk(8'h26, 8'h04, 1'b1, 8'h06);
        vecs[0]  = '{8'h86, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{8'h88, 8'h01, 8'h01, 1'b1};
        vecs[2]  = '{8'h89, 8'h5A, 8'h5A, 1'b1};
        vecs[3]  = '{8'h96, 8'h3C, 8'h3C, 1'b1};
        vecs[4]  = '{8'h97, 8'hFF, 8'hFF, 1'b1};
        vecs[5]  = '{8'h20, 8'h11, 8'h11, 1'b1};
        vecs[6]  = '{8'h28, 8'h22, 8'h22, 1'b1};
        vecs[7]  = '{8'h42, 8'h33, 8'h00, 1'b0};
        vecs[8]  = '{8'h4D, 8'h44, 8'h00, 1'b0};
        vecs[9]  = '{8'h87, 8'h77, 8'h77, 1'b1};
        vecs[10] = '{8'h4A, 8'h66, 8'h00, 1'b0};
        vecs[11] = '{8'h21, 8'h9C, 8'h9C, 1'b1};

        for (int i = 0; i < 128; i++) rom[i] = 8'h42;
        rom[0] = 8'h86; rom[1] = 8'h00; rom[2] = 8'h88; rom[3] = 8'h01;
        rom[4] = 8'h42; rom[5] = 8'h4D; rom[6] = 8'h26; rom[7] = 8'h04;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_fields", dut_instr(), 0);
        check("rst_addr", bus.rom_address, 0);
        check("rst_trap", bus.trap, 0);

        // Straight-line program with the consumer always ready.
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            get_instr($sformatf("seq%0d", i));
            check($sformatf("seq%0d_instr", i), dut_instr(), t1[i]);
        end
        check("seq_end_pc", bus.rom_address, 8'h08);

        // Back-pressure: fields and address frozen, then restart latency.
        bus.instr_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        get_instr("hold_first");
        check("hold_first_instr", dut_instr(), t1[0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", bus.instr_valid, 1);
            check("hold_fields", dut_instr(), t1[0]);
            check("hold_addr", bus.rom_address, 8'h02);
        end
        pulse_ready();
        get_instr("hold_next2");
        check("hold_next2_instr", dut_instr(), t1[1]);
        check("hold_lat_2byte", lat, 4);
        pulse_ready();
        get_instr("hold_next1");
        check("hold_next1_instr", dut_instr(), t1[2]);
        check("hold_lat_1byte", lat, 2);

        // Redirect while the operand of 26 04 is being latched.
        redirect(8'h06);
        repeat (3) @(negedge clk);
        check("lat_opr_addr", bus.rom_address, 8'h07);
        redirect(8'h04);
        get_instr("redir_opr");
        check("redir_opr_instr", dut_instr(), t1[2]);
        check("redir_opr_lat", lat, 2);

        // Redirect coinciding with a transfer; target reduced modulo the ROM depth.
        bus.instr_ready = 1'b1;
        redirect(8'h85);
        bus.instr_ready = 1'b0;
        check("redir_mod_addr", bus.rom_address, 8'h05);
        check("redir_mod_valid", bus.instr_valid, 0);
        get_instr("redir_mod");
        check("redir_mod_instr", dut_instr(), t1[3]);

        // Opcode in the last ROM word takes its operand from word 0.
        rom[127] = 8'h20;
        rom[0]   = 8'h05;
        redirect(8'h7F);
        get_instr("wrap");
        check("wrap_instr", dut_instr(), mk(8'h20, 8'h05, 1'b1, 8'h7F));
        check("wrap_pc", bus.rom_address, 8'h01);
        rom[0] = 8'h86;

        // Illegal opcode.
        rom[8'h10] = 8'hFF;
        rom[8'h11] = 8'h42;
        rom[8'h7E] = 8'h43;
        redirect(8'h10);
        get_instr("illegal");
`ifdef IFU_ILLEGAL_TRAP_EN
        check("illegal_trap_cnt", traps, 1);
        check("illegal_instr", dut_instr(), mk(8'h43, 8'h00, 1'b0, 8'h7E));
`else
        check("illegal_trap_cnt", traps, 0);
        check("illegal_instr", dut_instr(), mk(8'hFF, 8'h00, 1'b0, 8'h10));
`endif

        for (int i = 0; i < 12; i++) begin
            rom[8'h40] = vecs[i].b0;
            rom[8'h41] = vecs[i].b1;
            redirect(8'h40);
            get_instr($sformatf("vec%0d", i));
            check($sformatf("vec%0d_instr", i), dut_instr(), mk(vecs[i].b0, vecs[i].opr, vecs[i].tb, 8'h40));
            check($sformatf("vec%0d_pc", i), bus.rom_address, vecs[i].tb ? 8'h42 : 8'h41);
        end

        // Reset in the middle of an operand fetch.
        redirect(8'h00);
        repeat (2) @(negedge clk);
        check("mid_rst_pre_addr", bus.rom_address, 8'h01);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", bus.instr_valid, 0);
        check("mid_rst_addr", bus.rom_address, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        get_instr("mid_rst");
        check("mid_rst_instr", dut_instr(), t1[0]);

        // Randomized run against the ROM-walk model.
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mpc = 0;
        gap = -1;
        transfers = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (gap >= 0) gap++;
            e_ins = model_instr(mpc, nxt);
`ifndef IFU_ILLEGAL_TRAP_EN
            if (bus.instr_valid && gap >= 0) begin
                check("rand_latency", gap, e_ins[8] ? 5 : 3);
                gap = -1;
            end
`endif
            bus.instr_ready    = ($urandom_range(3) != 0);
            bus.redirect_valid = ($urandom_range(24) == 0);
            bus.redirect_addr  = 8'($urandom);
            if (bus.instr_valid && bus.instr_ready) begin
                check("rand_instr", dut_instr(), e_ins);
                mpc = nxt;
                transfers++;
                gap = 0;
            end
            if (bus.redirect_valid) begin
                mpc = int'(bus.redirect_addr) % 128;
                gap = 0;
            end
        end
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        check("rand_transfers", transfers > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
